// File: rtl/vram_pixel_writer.sv
// 64x32 monochrome frame store for the VMA412 driver: registered row-read port
// plus a valid/ready pixel command port applied by read-modify-write of whole rows.
module vram_pixel_writer (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rd_address,
    output logic [63:0] rd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_x,
    input  logic [4:0]  cmd_y,
    output logic        cmd_done,
    output logic        busy
);

    typedef enum logic [1:0] {CLR, IDLE, RD, WR} state_t;

    state_t      state, state_next;
    logic [4:0]  clr_row, clr_row_next;
    logic        clr_by_op, clr_by_op_next;
    logic        done_next;
    logic        accept;

    logic [1:0]  op_q;
    logic [5:0]  x_q;
    logic [4:0]  y_q;
    logic [63:0] row_buf;
    logic [63:0] mem [32];

    logic        wr_en;
    logic [4:0]  wr_row;
    logic [63:0] wr_data;

    function automatic logic [63:0] apply_op(input logic [63:0] row,
                                             input logic [1:0]  op,
                                             input logic [5:0]  x);
        logic [63:0] r;
        r = row;
        case (op)
            2'd0:    r[x] = 1'b1;
            2'd1:    r[x] = 1'b0;
            default: r[x] = ~row[x];
        endcase
        return r;
    endfunction

    assign cmd_ready = (state == IDLE);
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_next     = state;
        clr_row_next   = clr_row;
        clr_by_op_next = clr_by_op;
        done_next      = 1'b0;
        wr_en          = 1'b0;
        wr_row         = clr_row;
        wr_data        = '0;
        case (state)
            CLR: begin
                wr_en        = 1'b1;
                clr_row_next = clr_row + 5'd1;
                if (clr_row == 5'd31) begin
                    state_next     = IDLE;
                    done_next      = clr_by_op;
                    clr_by_op_next = 1'b0;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (cmd_op == 2'd3) begin
                        state_next     = CLR;
                        clr_row_next   = 5'd0;
                        clr_by_op_next = 1'b1;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: state_next = WR;
            WR: begin
                wr_en      = 1'b1;
                wr_row     = y_q;
                wr_data    = apply_op(row_buf, op_q, x_q);
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = CLR;
        endcase
    end

    // control: reset aborts anything in flight and restarts the sweep
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= CLR;
            clr_row   <= 5'd0;
            clr_by_op <= 1'b0;
            cmd_done  <= 1'b0;
        end else begin
            state     <= state_next;
            clr_row   <= clr_row_next;
            clr_by_op <= clr_by_op_next;
            cmd_done  <= done_next;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            op_q <= cmd_op;
            x_q  <= cmd_x;
            y_q  <= cmd_y;
        end
        if (state == RD)
            row_buf <= mem[y_q];
    end

    // writes are suppressed while reset is asserted so an aborted op leaves no trace
    always_ff @(posedge clock) begin
        if (reset && wr_en)
            mem[wr_row] <= wr_data;
    end

    // display port reads the pre-write value when the same row is written this edge
    always_ff @(posedge clock) begin
        if (!reset)
            rd_data <= '0;
        else
            rd_data <= mem[rd_address];
    end

endmodule
